// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: FSM state encoding,
// alarm time moduli and binary-to-BCD digit helpers.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } alarm_state_e;

  localparam int unsigned MinMod = 60;
  localparam int unsigned HrMod  = 24;

  localparam logic [5:0] MinLast = 6'(MinMod - 1);
  localparam logic [4:0] HrLast  = 5'(HrMod - 1);

  // Tens digit of a binary value 0..59.
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  // Units digit of a binary value 0..59.
  function automatic logic [3:0] bcd_units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/alarm_time_reg.sv
// Alarm time storage: binary minute/hour registers with wrapping increment
// (no carry from minutes into hours) and combinational BCD digit outputs.
module alarm_time_reg
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] al_min_units,
  output logic [2:0] al_min_tens,
  output logic [3:0] al_hr_units,
  output logic [1:0] al_hr_tens
);

  logic [5:0] al_min_q, al_min_d;
  logic [4:0] al_hr_q, al_hr_d;

  // Next alarm time: edits only take effect in set mode; both pulses may apply together.
  always_comb begin
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    if (set_mode && inc_min) begin
      al_min_d = (al_min_q == MinLast) ? 6'd0 : al_min_q + 6'd1;
    end
    if (set_mode && inc_hour) begin
      al_hr_d = (al_hr_q == HrLast) ? 5'd0 : al_hr_q + 5'd1;
    end
  end

  // Alarm time registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_min_q <= 6'd0;
      al_hr_q  <= 5'd0;
    end else begin
      al_min_q <= al_min_d;
      al_hr_q  <= al_hr_d;
    end
  end

  // BCD split for the compare logic and the display mux.
  always_comb begin
    al_min_units = bcd_units(al_min_q);
    al_min_tens  = 3'(bcd_tens(al_min_q));
    al_hr_units  = bcd_units({1'b0, al_hr_q});
    al_hr_tens   = 2'(bcd_tens({1'b0, al_hr_q}));
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares running time against the alarm time, fires one
// trigger per minute match and runs the ringing FSM with auto-stop timeout.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned CNT_W       = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [5:0] seconds,
  input  logic [3:0] minutes_units,
  input  logic [2:0] minutes_tens,
  input  logic [3:0] hours_units,
  input  logic [1:0] hours_tens,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] al_min_units,
  output logic [2:0] al_min_tens,
  output logic [3:0] al_hr_units,
  output logic [1:0] al_hr_tens,
  output logic       ringing,
  output logic       buzz
);

  localparam logic [CNT_W-1:0] RingLast = CNT_W'(RING_SECS - 1);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buzz_q, buzz_d;
  logic             match, match_q, trigger;
  logic             snooze_act;

  alarm_time_reg u_time_reg (
    .clk          (clk),
    .reset        (reset),
    .set_mode     (set_mode),
    .inc_min      (inc_min),
    .inc_hour     (inc_hour),
    .al_min_units (al_min_units),
    .al_min_tens  (al_min_tens),
    .al_hr_units  (al_hr_units),
    .al_hr_tens   (al_hr_tens)
  );

`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SnoozeLast = CNT_W'(SNOOZE_SECS - 1);
  assign snooze_act = snooze;
`else
  logic unused_cfg;
  assign snooze_act = 1'b0;
  assign unused_cfg = snooze ^ (SNOOZE_SECS == 0);
`endif

  // Time match; blocked while editing so a half-edited alarm cannot fire.
  always_comb begin
    match = alarm_en && !set_mode && (seconds == 6'd0) &&
            (minutes_units == al_min_units) && (minutes_tens == al_min_tens) &&
            (hours_units == al_hr_units) && (hours_tens == al_hr_tens);
    trigger = match && !match_q;
  end

  // Next-state logic; priority is stop > alarm_en low > snooze > tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buzz_d  = buzz_q;
    unique case (state_q)
      StIdle: begin
        buzz_d = 1'b0;
        if (trigger) begin
          state_d = StRinging;
          cnt_d   = '0;
          buzz_d  = 1'b1;
        end
      end
      StRinging: begin
        if (stop || !alarm_en) begin
          state_d = StIdle;
          cnt_d   = '0;
          buzz_d  = 1'b0;
        end else if (snooze_act) begin
          state_d = StSnooze;
          cnt_d   = '0;
          buzz_d  = 1'b0;
        end else if (sec_tick) begin
          if (cnt_q == RingLast) begin
            state_d = StIdle;
            cnt_d   = '0;
            buzz_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            buzz_d = !buzz_q;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      StSnooze: begin
        buzz_d = 1'b0;
        if (stop || !alarm_en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sec_tick) begin
          if (cnt_q == SnoozeLast) begin
            state_d = StRinging;
            cnt_d   = '0;
            buzz_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        buzz_d  = 1'b0;
      end
    endcase
  end

  // State, counter, buzzer and match-edge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buzz_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buzz_q  <= buzz_d;
      match_q <= match;
    end
  end

  assign ringing = (state_q == StRinging);
  assign buzz    = buzz_q;

endmodule
